// File: rtl/score_display_pkg.sv
// Shared constants, types and helpers for the score display block:
// segment patterns, BCD geometry, conversion FSM states and the double-dabble step.
package score_display_pkg;

  localparam int unsigned BCD_DIGITS = 5;
  localparam int unsigned BIN_W      = 16;
  localparam int unsigned NUM_AN     = 4;
  localparam int unsigned BCD_W      = BCD_DIGITS * 4;

  // Segment order is {g,f,e,d,c,b,a}, active-low.
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_COMMIT = 2'd2
  } conv_state_e;

  function automatic int unsigned cnt_width(input int unsigned n);
    if (n <= 32'd1) begin
      return 32'd1;
    end else begin
      return $clog2(n);
    end
  endfunction

  // Pre-shift correction: every BCD nibble >= 5 gets 3 added.
  function automatic logic [BCD_W-1:0] dabble_adjust(input logic [BCD_W-1:0] bcd);
    logic [BCD_W-1:0] adj;
    adj = bcd;
    for (int i = 0; i < BCD_DIGITS; i++) begin
      if (bcd[i*4 +: 4] >= 4'd5) begin
        adj[i*4 +: 4] = bcd[i*4 +: 4] + 4'd3;
      end else begin
        adj[i*4 +: 4] = bcd[i*4 +: 4];
      end
    end
    return adj;
  endfunction

endpackage

// File: rtl/score_display_bcd_to_seg7.sv
// Combinational decimal digit to active-low 7-segment pattern, with a blank override.
module bcd_to_seg7
  import score_display_pkg::*;
(
  input  logic [3:0] digit,
  input  logic       blank,
  output logic [6:0] seg
);

  // Pattern lookup; codes above 9 never reach here but still map to dark.
  always_comb begin
    seg = SEG_BLANK;
    if (blank) begin
      seg = SEG_BLANK;
    end else begin
      case (digit)
        4'd0:    seg = SEG_0;
        4'd1:    seg = SEG_1;
        4'd2:    seg = SEG_2;
        4'd3:    seg = SEG_3;
        4'd4:    seg = SEG_4;
        4'd5:    seg = SEG_5;
        4'd6:    seg = SEG_6;
        4'd7:    seg = SEG_7;
        4'd8:    seg = SEG_8;
        4'd9:    seg = SEG_9;
        default: seg = SEG_BLANK;
      endcase
    end
  end

endmodule

// File: rtl/score_display.sv
// Score to 4-digit multiplexed 7-segment display: sequential double-dabble conversion,
// leading-zero blanking, overflow saturation at 9999 and blinking while the game is over.
module score_display
  import score_display_pkg::*;
#(
  parameter int unsigned CLK_HZ    = 100_000_000,
  parameter int unsigned SCAN_HZ   = 1000,
  parameter int unsigned BLINK_DIV = 25_000_000
) (
  input  logic              clk_100MHz,
  input  logic              reset_n,
  input  logic [BIN_W-1:0]  score,
  input  logic              score_valid,
  input  logic              status,
  output logic [6:0]        seg,
  output logic              dp,
  output logic [NUM_AN-1:0] an,
  output logic              busy
);

  localparam int unsigned SCAN_DIV = CLK_HZ / SCAN_HZ;
  localparam int unsigned SCAN_W   = cnt_width(SCAN_DIV);
  localparam int unsigned BLINK_W  = cnt_width(BLINK_DIV);
  localparam logic [SCAN_W-1:0]  SCAN_LAST  = SCAN_W'(SCAN_DIV - 32'd1);
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 32'd1);

  conv_state_e          state_r;
  conv_state_e          state_next_s;
  logic                 load_s;
  logic                 shift_s;
  logic                 commit_s;
  logic [BIN_W-1:0]     cap_s;
  logic [BCD_W-1:0]     adj_s;

  logic [BIN_W-1:0]     bin_r;
  logic [BCD_W-1:0]     bcd_r;
  logic [3:0]           iter_r;
  logic [BIN_W-1:0]     pend_val_r;
  logic                 pend_r;

  logic [NUM_AN*4-1:0]  disp_r;
  logic                 ovf_r;

  logic [SCAN_W-1:0]    scan_cnt_r;
  logic [1:0]           idx_r;
  logic [BLINK_W-1:0]   blink_cnt_r;
  logic                 phase_on_r;

  logic [3:0]           digit_s;
  logic                 upper_nz_s;
  logic                 blank_s;
  logic [6:0]           seg_pat_s;

  logic [6:0]           seg_r;
  logic                 dp_r;
  logic [NUM_AN-1:0]    an_r;
  logic                 busy_r;

  // Conversion state register.
  always_ff @(posedge clk_100MHz or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Conversion next-state logic; 16 shift cycles then one commit cycle.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (score_valid || pend_r) begin
          state_next_s = ST_SHIFT;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        if (iter_r == 4'd15) begin
          state_next_s = ST_COMMIT;
        end else begin
          state_next_s = ST_SHIFT;
        end
      end
      ST_COMMIT: state_next_s = ST_IDLE;
      default:   state_next_s = ST_IDLE;
    endcase
  end

  // Conversion control decode.
  always_comb begin
    load_s   = 1'b0;
    shift_s  = 1'b0;
    commit_s = 1'b0;
    case (state_r)
      ST_IDLE:   load_s   = score_valid || pend_r;
      ST_SHIFT:  shift_s  = 1'b1;
      ST_COMMIT: commit_s = 1'b1;
      default:   load_s   = 1'b0;
    endcase
  end

  // The live bus beats a held pending value when both are present in IDLE.
  assign cap_s = score_valid ? score : pend_val_r;
  assign adj_s = dabble_adjust(bcd_r);

  // Double-dabble shift register and iteration counter.
  always_ff @(posedge clk_100MHz or negedge reset_n) begin
    if (!reset_n) begin
      bin_r  <= '0;
      bcd_r  <= '0;
      iter_r <= 4'd0;
    end else if (load_s) begin
      bin_r  <= cap_s;
      bcd_r  <= '0;
      iter_r <= 4'd0;
    end else if (shift_s) begin
      {bcd_r, bin_r} <= {adj_s, bin_r} << 6'd1;
      iter_r         <= iter_r + 4'd1;
    end else begin
      bin_r  <= bin_r;
      bcd_r  <= bcd_r;
      iter_r <= iter_r;
    end
  end

  // Strobes arriving mid-conversion are held; only the latest survives.
  always_ff @(posedge clk_100MHz or negedge reset_n) begin
    if (!reset_n) begin
      pend_r     <= 1'b0;
      pend_val_r <= '0;
    end else if (score_valid && (state_r != ST_IDLE)) begin
      pend_r     <= 1'b1;
      pend_val_r <= score;
    end else if (load_s) begin
      pend_r     <= 1'b0;
      pend_val_r <= pend_val_r;
    end else begin
      pend_r     <= pend_r;
      pend_val_r <= pend_val_r;
    end
  end

  // Display digit registers; a non-zero fifth digit saturates to 9999.
  always_ff @(posedge clk_100MHz or negedge reset_n) begin
    if (!reset_n) begin
      disp_r <= '0;
      ovf_r  <= 1'b0;
    end else if (commit_s) begin
      if (bcd_r[BCD_W-1 -: 4] != 4'd0) begin
        disp_r <= 16'h9999;
        ovf_r  <= 1'b1;
      end else begin
        disp_r <= bcd_r[NUM_AN*4-1:0];
        ovf_r  <= 1'b0;
      end
    end else begin
      disp_r <= disp_r;
      ovf_r  <= ovf_r;
    end
  end

  // Digit scan prescaler and index.
  always_ff @(posedge clk_100MHz or negedge reset_n) begin
    if (!reset_n) begin
      scan_cnt_r <= '0;
      idx_r      <= 2'd0;
    end else if (scan_cnt_r == SCAN_LAST) begin
      scan_cnt_r <= '0;
      idx_r      <= idx_r + 2'd1;
    end else begin
      scan_cnt_r <= scan_cnt_r + SCAN_W'(1);
      idx_r      <= idx_r;
    end
  end

  // Blink timer; held in the on phase while the game runs.
  always_ff @(posedge clk_100MHz or negedge reset_n) begin
    if (!reset_n) begin
      blink_cnt_r <= '0;
      phase_on_r  <= 1'b1;
    end else if (status) begin
      blink_cnt_r <= '0;
      phase_on_r  <= 1'b1;
    end else if (blink_cnt_r == BLINK_LAST) begin
      blink_cnt_r <= '0;
      phase_on_r  <= ~phase_on_r;
    end else begin
      blink_cnt_r <= blink_cnt_r + BLINK_W'(1);
      phase_on_r  <= phase_on_r;
    end
  end

  // Current digit select and leading-zero blanking.
  always_comb begin
    digit_s    = disp_r[{idx_r, 2'b00} +: 4];
    upper_nz_s = 1'b0;
    for (int i = 0; i < NUM_AN; i++) begin
      if ((i >= int'(idx_r)) && (disp_r[i*4 +: 4] != 4'd0)) begin
        upper_nz_s = 1'b1;
      end else begin
        upper_nz_s = upper_nz_s;
      end
    end
    blank_s = (idx_r != 2'd0) && !ovf_r && !upper_nz_s;
  end

  bcd_to_seg7 u_bcd_to_seg7 (
    .digit (digit_s),
    .blank (blank_s),
    .seg   (seg_pat_s)
  );

  // Output registers.
  always_ff @(posedge clk_100MHz or negedge reset_n) begin
    if (!reset_n) begin
      seg_r  <= SEG_BLANK;
      dp_r   <= 1'b1;
      an_r   <= 4'b1111;
      busy_r <= 1'b0;
    end else begin
      seg_r  <= seg_pat_s;
      dp_r   <= ~ovf_r;
      an_r   <= phase_on_r ? ~(4'b0001 << idx_r) : 4'b1111;
      busy_r <= (state_next_s != ST_IDLE);
    end
  end

  assign seg  = seg_r;
  assign dp   = dp_r;
  assign an   = an_r;
  assign busy = busy_r;

endmodule

// File: tb/tb_score_display.sv
// Randomized self-checking bench for score_display against a decimal-arithmetic display model.
module tb_score_display;

  logic        clk_100MHz = 1'b0;
  logic        reset_n    = 1'b0;
  logic [15:0] score      = 16'd0;
  logic        score_valid = 1'b0;
  logic        status     = 1'b1;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;
  logic        busy;

  int total = 0;
  int bad   = 0;

  logic [6:0] seg_tab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                               7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

  score_display #(
    .CLK_HZ    (1000),
    .SCAN_HZ   (250),
    .BLINK_DIV (20)
  ) dut (
    .clk_100MHz  (clk_100MHz),
    .reset_n     (reset_n),
    .score       (score),
    .score_valid (score_valid),
    .status      (status),
    .seg         (seg),
    .dp          (dp),
    .an          (an),
    .busy        (busy)
  );

  always #5 clk_100MHz = ~clk_100MHz;

  initial begin
    #300000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
    end
  endtask

  // Expected pattern of one slot: saturate at 9999, blank any slot above the leading digit.
  function automatic logic [6:0] exp_seg(input int unsigned val, input int slot);
    int unsigned v;
    int unsigned p;
    v = (val > 9999) ? 9999 : val;
    p = 10 ** slot;
    if (slot != 0 && v < p) return 7'b1111111;
    return seg_tab[(v / p) % 10];
  endfunction

  function automatic int an_slot(input logic [3:0] a);
    int s;
    s = -1;
    for (int i = 0; i < 4; i++) begin
      if (a == ~(4'b0001 << i)) s = i;
    end
    return s;
  endfunction

  task automatic tick();
    @(posedge clk_100MHz);
    #1;
  endtask

  task automatic check_slot(input int unsigned val);
    int s;
    s = an_slot(an);
    check_val("an_onehot", 32'(s >= 0), 32'd1);
    if (s >= 0) begin
      check_val("seg", 32'(seg), 32'(exp_seg(val, s)));
      check_val("dp", 32'(dp), 32'(val <= 9999));
    end
  endtask

  task automatic watch_display(input int unsigned val, input int n);
    logic [3:0] seen;
    int s;
    seen = 4'b0000;
    for (int c = 0; c < n; c++) begin
      tick();
      check_slot(val);
      s = an_slot(an);
      if (s >= 0) seen[s] = 1'b1;
    end
    check_val("slots_seen", 32'(seen), 32'hF);
  endtask

  task automatic pulse(input logic [15:0] v);
    score       = v;
    score_valid = 1'b1;
    tick();
    score_valid = 1'b0;
  endtask

  task automatic wait_idle(output int cyc);
    cyc = 0;
    while (busy === 1'b1 && cyc < 100) begin
      tick();
      cyc++;
    end
    check_val("idle_timeout", 32'(cyc < 100), 32'd1);
  endtask

  task automatic convert_and_check(input logic [15:0] v);
    int cyc;
    pulse(v);
    wait_idle(cyc);
    check_val("busy_len", 32'(cyc), 32'd17);
    watch_display(32'(v), 16);
  endtask

  initial begin
    int cyc;
    int gap;
    int unsigned cur_val;
    int unsigned new_val;
    logic [15:0] va;
    logic [15:0] vb;
    logic [15:0] vc;
    logic [15:0] fixed [14] = '{16'd1234, 16'd7, 16'd0, 16'd65535, 16'd10000, 16'd9999,
                                16'd9, 16'd10, 16'd99, 16'd100, 16'd999, 16'd1000,
                                16'd5678, 16'd8060};
    logic dark;

    // Reset held
    repeat (3) tick();
    check_val("rst_an", 32'(an), 32'hF);
    check_val("rst_seg", 32'(seg), 32'h7F);
    check_val("rst_dp", 32'(dp), 32'd1);
    check_val("rst_busy", 32'(busy), 32'd0);
    reset_n = 1'b1;
    tick();
    check_val("rel_an", 32'(an), 32'hE);
    check_val("rel_seg", 32'(seg), 32'h40);
    watch_display(0, 16);

    // Boundary values then random scores
    foreach (fixed[i]) convert_and_check(fixed[i]);
    for (int i = 0; i < 8; i++) begin
      if (i % 2 == 0) convert_and_check(16'($urandom_range(0, 9999)));
      else convert_and_check(16'($urandom_range(0, 65535)));
    end

    // Strobes while busy: latest pending wins
    pulse(16'd42);
    repeat (2) tick();
    pulse(16'd99);
    repeat (2) tick();
    pulse(16'd123);
    wait_idle(cyc);
    watch_display(42, 16);
    wait_idle(cyc);
    gap = 16 + cyc;
    check_val("commit_gap", 32'(gap), 32'd18);
    watch_display(123, 16);
    repeat (10) tick();
    check_val("no_extra_conv", 32'(busy), 32'd0);

    // Pending set during COMMIT, then live strobe in IDLE: bus value wins
    va = 16'($urandom_range(0, 3333));
    vb = 16'($urandom_range(3334, 6666));
    vc = 16'($urandom_range(6667, 9999));
    pulse(va);
    repeat (16) tick();
    pulse(vb);
    check_val("commit_busy_low", 32'(busy), 32'd0);
    pulse(vc);
    wait_idle(cyc);
    watch_display(32'(vc), 16);
    gap = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (busy === 1'b1) gap++;
    end
    check_val("bus_wins_no_rerun", 32'(gap), 32'd0);
    watch_display(32'(vc), 16);
    cur_val = 32'(vc);

    // Blink with a simultaneous strobe; new value visible 18 edges later
    new_val = $urandom_range(0, 65535);
    status      = 1'b0;
    score       = 16'(new_val);
    score_valid = 1'b1;
    for (int k = 1; k <= 100; k++) begin
      tick();
      score_valid = 1'b0;
      dark = (an == 4'b1111);
      check_val("blink_dark", 32'(dark), 32'(((k - 1) / 20) % 2 == 1));
      if (!dark) check_slot((k >= 19) ? new_val : cur_val);
    end
    cur_val = new_val;
    status = 1'b1;
    repeat (2) tick();
    watch_display(cur_val, 40);

    // Reset during SHIFT aborts conversion
    pulse(16'd4321);
    repeat (5) tick();
    check_val("pre_rst_busy", 32'(busy), 32'd1);
    reset_n = 1'b0;
    #1;
    check_val("mid_rst_busy", 32'(busy), 32'd0);
    check_val("mid_rst_an", 32'(an), 32'hF);
    check_val("mid_rst_seg", 32'(seg), 32'h7F);
    check_val("mid_rst_dp", 32'(dp), 32'd1);
    tick();
    reset_n = 1'b1;
    tick();
    check_val("rel2_an", 32'(an), 32'hE);
    check_val("rel2_seg", 32'(seg), 32'h40);
    check_val("rel2_busy", 32'(busy), 32'd0);
    watch_display(0, 16);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/score_display.md
Name: score_display

Overview:
- Downstream consumer of the game's 16-bit `score` register.
- Converts binary score to BCD with a sequential double-dabble engine.
- Drives the Basys 3 4-digit multiplexed 7-segment display: leading-zero blanking, overflow saturation, blinking while the game is over.
- Instantiated in top beside pixel_generation; fed by `score`, `status` and `refresh_tick`.

Parameters:
- CLK_HZ, 100_000_000: input clock frequency.
- SCAN_HZ, 1000: digit-advance rate; each digit is lit for CLK_HZ/SCAN_HZ cycles.
- BLINK_DIV, 25_000_000: cycles per blink half-period while status=0 (2 Hz blink at 100 MHz).

Ports:
- clk_100MHz  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- score  in  16  unsigned binary score.
- score_valid  in  1  single-cycle update strobe (tied to refresh_tick).
- status  in  1  1 = game running, 0 = game over.
- seg  out  7  {g,f,e,d,c,b,a}, active-low.
- dp  out  1  decimal point, active-low.
- an  out  4  digit anodes, active-low; an[0] is the rightmost digit.
- busy  out  1  conversion in progress.

Behaviour:
- One clock; reset_n is asynchronous, active-low.
- Reset values:
  - seg=7'b1111111, dp=1, an=4'b1111, busy=0.
  - Display digit registers = 0; scan index=0; prescaler=0; blink counter=0; pending=0.
- Reset asserted mid-conversion aborts the conversion. After release, the display shows "0".
- All outputs are registered. The first clock after reset release drives an=4'b1110, seg=7'b1000000.
- Conversion FSM states are IDLE, SHIFT, COMMIT.
  - IDLE with score_valid=1 or pending=1: load the 16-bit shift register with the capture value, clear the 20-bit BCD accumulator, clear the iteration count, go to SHIFT.
  - SHIFT, each cycle: add 3 to every BCD nibble >=5, then shift {bcd,bin} left by 1. After 16 SHIFT cycles go to COMMIT.
  - COMMIT: write the BCD result to the display registers, go to IDLE.
- busy=1 in SHIFT and COMMIT.
- Latency: strobe sampled at edge N; display registers update at edge N+17; new digits are visible on outputs from edge N+18.
- score_valid while busy: latch score into the pending register and set pending. A later strobe overwrites the pending value (latest wins). pending clears when IDLE consumes it.
- score_valid in IDLE with pending=1: the score on the bus wins, and pending clears.
- Overflow: if BCD digit 4 is non-zero (score >= 10000), the committed digits are 9,9,9,9 and the overflow flag is set.
  - overflow=1: dp=0 on every digit.
  - overflow=0: dp=1.
- Scan:
  - Prescaler counts 0..CLK_HZ/SCAN_HZ-1. On wrap, the scan index increments modulo 4 (3 -> 0).
  - an = ~(4'b0001 << idx).
  - seg = the pattern of digit[idx].
- Leading-zero blanking: a digit above the most significant non-zero digit outputs seg=7'b1111111. Digit 0 is never blanked. Overflow disables blanking.
- Segment patterns:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001.
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
- Blink:
  - status=1: blink counter held at 0, phase=on.
  - status=0: counter counts 0..BLINK_DIV-1; phase toggles on each wrap. First phase after status falls is on.
  - Phase off: an=4'b1111. Scan and conversion continue underneath.
- A status change and score_valid in the same cycle are independent; both take effect.

Decomposition:
- Shared package:
  - SEG_BLANK constant and the 10 segment-pattern constants.
  - BCD_DIGITS=5, BIN_W=16, NUM_AN=4.
  - Scan-counter width derived with $clog2(CLK_HZ/SCAN_HZ).
- Sub-module: bcd_to_seg7, purely combinational, mapping a 4-bit digit plus blank to a 7-bit active-low pattern.
- The double-dabble FSM, scan and blink logic stay in score_display.

Test Plan (simulate with CLK_HZ=1000, SCAN_HZ=250, BLINK_DIV=20):
- Reset behaviour: hold reset_n=0 -> an=1111, seg=1111111, dp=1, busy=0. Release -> an=1110, seg=1000000; slots 1-3 show seg=1111111.
- Basic conversion: score=1234 pulse -> busy=1 for exactly 17 cycles; from edge N+18, slot 0..3 show seg 0011001, 0110000, 0100100, 1111001 with an 1110, 1101, 1011, 0111.
- Blanking and zero: score=7 -> slot 0 seg=1111000, slots 1-3 seg=1111111. score=0 -> slot 0 seg=1000000.
- Overflow: score=65535 and score=10000 -> every slot seg=0010000 (9), dp=0. Then score=9999 -> same digits, dp=1.
- Strobes during conversion: strobe 42, then 99 and 123 while busy -> display shows 42, then 123 (99 discarded) 18 cycles after the first COMMIT.
- Blink and mid-conversion reset: status=0 -> an=1111 on alternating 20-cycle windows; digits scan normally in on windows. status=1 -> continuous display. reset_n=0 during SHIFT -> busy=0 immediately; after release, "0" is displayed.
